// File: rtl/shift_normalizer_if.sv
// Handshake bundle for the shift normalizer: start/mode/din request,
// busy/done status and count/dout/zero result.
interface shift_normalizer_if #(
  parameter int WIDTH = 32
);
  localparam int LG = $clog2(WIDTH);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [LG:0]      count;
  logic [WIDTH-1:0] dout;
  logic             zero;

  modport master (
    output start, mode, din,
    input  busy, done, count, dout, zero
  );

  modport slave (
    input  start, mode, din,
    output busy, done, count, dout, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// Multi-cycle CLZ/CLS counter: binary search, one step per clock.
// Ports: clk, rst_n (async low), bus (slave: start/mode/din -> busy/done/count/dout/zero).
module shift_normalizer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  shift_normalizer_if.slave bus
);
  localparam int LG = $clog2(WIDTH);
  localparam int CW = LG + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FIN    = 2'd2
  } state_e;

  state_e           state_q;
  logic             mode_q;
  logic             sign_q;
  logic             zcap_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic [LG-1:0]    w_q;

  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             zero_q;

  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    cnt_d;

  // Top w bits of the word.
  assign hi_mask = ~({WIDTH{1'b1}} >> w_q);

  always_comb begin
    work_d = work_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if ((work_q & hi_mask) == '0) begin
      work_d = work_q << w_q;
      data_d = data_q << w_q;
      cnt_d  = cnt_q + CW'(w_q);
    end
    // Last step: an all-zero work word needs one extra count.
    if (w_q == LG'(1) && !work_d[WIDTH-1]) begin
      cnt_d  = cnt_d + CW'(1);
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      zcap_q  <= 1'b0;
      work_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      dout_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            sign_q  <= bus.din[WIDTH-1] & bus.mode;
            zcap_q  <= (bus.din == '0);
            data_q  <= bus.din;
            work_q  <= bus.mode
                     ? bus.din ^ {WIDTH{bus.din[WIDTH-1]}}
                     : bus.din;
            cnt_q   <= '0;
            w_q     <= LG'(WIDTH / 2);
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          work_q <= work_d;
          data_q <= data_d;
          cnt_q  <= cnt_d;
          w_q    <= w_q >> 1;
          if (w_q == LG'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          zero_q <= zcap_q;
          if (mode_q) begin
            // Work had its sign bit cleared, so cnt counts one bit too many.
            count_q <= cnt_q - CW'(1);
            dout_q  <= {sign_q, data_q[WIDTH-1:1]};
          end else begin
            count_q <= cnt_q;
            dout_q  <= data_q;
          end
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.dout  = dout_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: directed vectors plus a
// linear-scan reference model for random operands.
module tb_shift_normalizer;
  logic clk;
  logic rst_n;

  shift_normalizer_if #(.WIDTH(32)) bus ();

  shift_normalizer #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] d;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = sb.pop_front();
          chk("count", 64'(bus.count), 64'(e.c));
          chk("dout", 64'(bus.dout), 64'(e.d));
          chk("zero", 64'(bus.zero), 64'(e.z));
        end
      end
    end
  end

  function automatic exp_t model(input logic m, input logic [31:0] d);
    exp_t r;
    int   c;
    c = 0;
    if (!m) begin
      while (c < 32 && !d[31-c]) c++;
    end else begin
      while (c < 31 && d[30-c] == d[31]) c++;
    end
    r.c = 6'(c);
    r.d = (c == 32) ? 32'h0 : d << c;
    r.z = (d == 32'h0);
    return r;
  endfunction

  // Issue one op; optionally check latency and busy timing.
  task automatic issue(input logic m, input logic [31:0] d,
                       input exp_t e, input bit tchk);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.din   = d;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = $urandom;
    bus.mode  = ~m;
    if (tchk) chk("busy_after_start", 64'(bus.busy), 64'd1);
    k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
      if (tchk && k == 5) chk("busy_mid", 64'(bus.busy), 64'd1);
      if (tchk && k < 6) chk("no_early_done", 64'(bus.done), 64'd0);
    end
    if (k >= 20) chk("done_timeout", 64'(k), 64'd6);
    else if (tchk) begin
      chk("latency", 64'(k), 64'd6);
      chk("busy_at_done", 64'(bus.busy), 64'd0);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [31:0] d,
                              input logic z);
    exp_t r;
    r.c = 6'(c);
    r.d = d;
    r.z = z;
    return r;
  endfunction

  initial begin
    int d1, d2, nd;
    logic [31:0] rd;
    logic        rm;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.din   = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    rst_n = 1'b1;

    issue(1'b0, 32'h0001_0000, mk(15, 32'h8000_0000, 1'b0), 1'b1);
    issue(1'b0, 32'h0000_0000, mk(32, 32'h0000_0000, 1'b1), 1'b0);
    issue(1'b0, 32'h8000_0000, mk(0, 32'h8000_0000, 1'b0), 1'b0);
    issue(1'b1, 32'h0000_0005, mk(28, 32'h5000_0000, 1'b0), 1'b1);
    issue(1'b1, 32'hFFFF_FFFA, mk(28, 32'hA000_0000, 1'b0), 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, mk(31, 32'h8000_0000, 1'b0), 1'b0);
    issue(1'b1, 32'h4000_0000, mk(0, 32'h4000_0000, 1'b0), 1'b0);
    issue(1'b1, 32'h0000_0000, mk(31, 32'h0000_0000, 1'b1), 1'b0);
    issue(1'b1, 32'h8000_0000, mk(0, 32'h8000_0000, 1'b0), 1'b0);
    issue(1'b0, 32'h0000_0001, mk(31, 32'h8000_0000, 1'b0), 1'b0);

    // Start while busy is ignored; held start re-accepted at N+7.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.din   = 32'h1;
    sb.push_back(mk(31, 32'h8000_0000, 1'b0));
    sb.push_back(mk(32, 32'h0, 1'b1));
    d1 = 0;
    d2 = 0;
    nd = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.din   = 32'h0;
      end
      if (i == 8) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (nd == 1) d1 = i;
        if (nd == 2) d2 = i;
      end
    end
    chk("ign_first_done", 64'(d1), 64'd7);
    chk("ign_second_done", 64'(d2), 64'd14);
    chk("ign_done_count", 64'(nd), 64'd2);

    // Reset in the middle of SEARCH discards the op.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.din   = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_count", 64'(bus.count), 64'd0);
    chk("mrst_dout", 64'(bus.dout), 64'd0);
    chk("mrst_zero", 64'(bus.zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(1'b0, 32'h0000_00FF, mk(24, 32'hFF00_0000, 1'b0), 1'b1);

    for (int n = 0; n < 4000; n++) begin
      rd = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rd = ~rd;
      if ($urandom_range(0, 15) == 0) rd = '0;
      rm = 1'($urandom_range(0, 1));
      issue(rm, rd, model(rm, rd), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
